// File: rtl/operand_collector_pkg.sv
// Shared state encoding, default sizes and configuration checks for the operand collector.
package operand_collector_pkg;

  localparam int DEF_INPUT_BW   = 8;
  localparam int DEF_LAYER_NUM  = 3;
  localparam int DEF_ARRAY_SIZE = 8;
  localparam int DEF_OUTPUT_BW  = 11;
  localparam int CNT_W          = DEF_LAYER_NUM + 1;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_EVAL = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // The tree only works for a power-of-two operand count and an exact-width sum.
  function automatic bit cfg_ok(input int in_bw, input int layer_num,
                                input int array_size, input int out_bw);
    return (array_size == (1 << layer_num)) && (out_bw == in_bw + layer_num);
  endfunction

endpackage

// File: rtl/oc_slot_buf.sv
// Operand register file: one signed slot per tree input, with indexed write,
// clear-above-index for short batches, and synchronous reset to zero.
module oc_slot_buf
  import operand_collector_pkg::*;
#(
  parameter int INPUT_BW   = DEF_INPUT_BW,
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int IDX_W      = DEF_LAYER_NUM
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic signed [INPUT_BW-1:0] wr_data,
  input  logic                       clr_en,
  output logic signed [INPUT_BW-1:0] operands [ARRAY_SIZE]
);

  for (genvar gi = 0; gi < ARRAY_SIZE; gi++) begin : g_slot
    localparam logic [IDX_W-1:0] SLOT_IDX = IDX_W'(gi);
    logic signed [INPUT_BW-1:0] r_slot;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_slot <= '0;
      end else if (wr_en && (wr_idx == SLOT_IDX)) begin
        r_slot <= wr_data;
      end else if (clr_en && (SLOT_IDX > wr_idx)) begin
        r_slot <= '0;
      end
    end

    assign operands[gi] = r_slot;
  end

endmodule

// File: rtl/operand_collector.sv
// Operand collector: packs serial signed samples into the adder-tree operand array
// and registers the tree sum. Define OPERAND_COLLECTOR_OVERLAP_EN to fill the next batch during HOLD.
module operand_collector
  import operand_collector_pkg::*;
#(
  parameter int INPUT_BW   = DEF_INPUT_BW,
  parameter int LAYER_NUM  = DEF_LAYER_NUM,
  parameter int ARRAY_SIZE = DEF_ARRAY_SIZE,
  parameter int OUTPUT_BW  = DEF_OUTPUT_BW
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [INPUT_BW-1:0]  in_data,
  input  logic                        in_last,
  output logic signed [INPUT_BW-1:0]  operands [ARRAY_SIZE],
  input  logic signed [OUTPUT_BW-1:0] tree_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUTPUT_BW-1:0] out_sum,
  output logic [LAYER_NUM:0]          out_count
);

  localparam int IDX_W = LAYER_NUM;
  localparam int CW    = LAYER_NUM + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ARRAY_SIZE - 1);

  if (!cfg_ok(INPUT_BW, LAYER_NUM, ARRAY_SIZE, OUTPUT_BW)) begin : g_cfg_err
    $error("operand_collector: need ARRAY_SIZE == 2**LAYER_NUM and OUTPUT_BW == INPUT_BW+LAYER_NUM");
  end

  state_t                       r_state;
  logic [IDX_W-1:0]             r_idx;
  logic [CW-1:0]                r_cnt;
  logic signed [OUTPUT_BW-1:0]  r_out_sum;
  logic [CW-1:0]                r_out_count;
  logic                         r_out_valid;
`ifdef OPERAND_COLLECTOR_OVERLAP_EN
  logic                         r_full;
`endif

  logic          w_in_ready;
  logic          w_acc;
  logic          w_done;
  logic [CW-1:0] w_cnt_next;

  // Ready is combinational on rst so it drops the same cycle reset is asserted.
  always_comb begin
    w_in_ready = 1'b0;
    if (!rst) begin
      if (r_state == ST_FILL) begin
        w_in_ready = 1'b1;
      end
`ifdef OPERAND_COLLECTOR_OVERLAP_EN
      else if ((r_state == ST_HOLD) && !r_full) begin
        w_in_ready = 1'b1;
      end
`endif
    end
  end

  assign w_acc      = in_valid && w_in_ready;
  assign w_done     = (r_idx == LAST_IDX) || in_last;
  assign w_cnt_next = {1'b0, r_idx} + CW'(1);

  oc_slot_buf #(
    .INPUT_BW   (INPUT_BW),
    .ARRAY_SIZE (ARRAY_SIZE),
    .IDX_W      (IDX_W)
  ) u_slot_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (w_acc),
    .wr_idx   (r_idx),
    .wr_data  (in_data),
    .clr_en   (w_acc && in_last),
    .operands (operands)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_FILL;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_valid <= 1'b0;
`ifdef OPERAND_COLLECTOR_OVERLAP_EN
      r_full      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_acc) begin
            if (w_done) begin
              r_state <= ST_EVAL;
              r_cnt   <= w_cnt_next;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        ST_EVAL: begin
          r_out_sum   <= tree_result;
          r_out_count <= r_cnt;
          r_out_valid <= 1'b1;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: begin
`ifdef OPERAND_COLLECTOR_OVERLAP_EN
          // r_cnt may be overwritten here: the held count already lives in r_out_count.
          if (w_acc) begin
            if (w_done) begin
              r_full <= 1'b1;
              r_cnt  <= w_cnt_next;
              r_idx  <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_full || (w_acc && w_done)) begin
              r_full  <= 1'b0;
              r_state <= ST_EVAL;
            end else begin
              r_state <= ST_FILL;
            end
          end
`else
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_idx       <= '0;
            r_state     <= ST_FILL;
          end
`endif
        end
        default: begin
          r_state <= ST_FILL;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_operand_collector.sv
// Self-checking bench for operand_collector: random and directed batches scored
// against a queue-based model of accepted samples; the adder tree is modelled here.
module tb_operand_collector;

  localparam int INPUT_BW   = 8;
  localparam int LAYER_NUM  = 3;
  localparam int ARRAY_SIZE = 8;
  localparam int OUTPUT_BW  = 11;
`ifdef OPERAND_COLLECTOR_OVERLAP_EN
  localparam int PERIOD = ARRAY_SIZE + 1;
`else
  localparam int PERIOD = ARRAY_SIZE + 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;
  logic signed [INPUT_BW-1:0] in_data = '0;
  logic in_ready;
  logic out_valid;
  logic signed [INPUT_BW-1:0] operands [ARRAY_SIZE];
  logic signed [OUTPUT_BW-1:0] tree_result;
  logic signed [OUTPUT_BW-1:0] out_sum;
  logic [LAYER_NUM:0] out_count;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int xfer_cnt = 0;
  int mdl_q[$];
  int xfer_cyc_q[$];
  int xfer_sum_q[$];

  always #5 clk = ~clk;

  operand_collector #(
    .INPUT_BW   (INPUT_BW),
    .LAYER_NUM  (LAYER_NUM),
    .ARRAY_SIZE (ARRAY_SIZE),
    .OUTPUT_BW  (OUTPUT_BW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .operands    (operands),
    .tree_result (tree_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_count   (out_count)
  );

  // Adder tree stand-in: plain sign-extended sum of all operand slots.
  always_comb begin
    tree_result = '0;
    for (int k = 0; k < ARRAY_SIZE; k++)
      tree_result = tree_result + {{LAYER_NUM{operands[k][INPUT_BW-1]}}, operands[k]};
  end

  always @(posedge clk) begin
    cyc++;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      xfer_cnt++;
      xfer_cyc_q.push_back(cyc);
      xfer_sum_q.push_back(int'(out_sum));
    end
  end

  function automatic int model_sum();
    int s = 0;
    foreach (mdl_q[k]) s += mdl_q[k];
    return s;
  endfunction

  // Offers one sample and waits (bounded) until it is taken; records it in the model.
  task automatic push(input int d, input bit last);
    int t = 0;
    logic signed [INPUT_BW-1:0] d8;
    d8 = INPUT_BW'(d);
    in_valid = 1'b1;
    in_data  = d8;
    in_last  = last;
    while (in_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
    end else begin
      mdl_q.push_back(int'(d8));
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output bit timed_out);
    int t = 0;
    while (out_valid !== 1'b1 && t < 60) begin
      @(negedge clk);
      t++;
    end
    timed_out = (out_valid !== 1'b1);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    total++; if (out_sum !== '0) begin bad++; $display("FAIL rst_out_sum: got %0d required 0", out_sum); end
    total++; if (out_count !== '0) begin bad++; $display("FAIL rst_out_count: got %0d required 0", out_count); end
    for (int k = 0; k < ARRAY_SIZE; k++) begin
      total++;
      if (operands[k] !== '0) begin bad++; $display("FAIL rst_slot%0d: got %0d required 0", k, operands[k]); end
    end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
    $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
  endtask

  task automatic test_full;
    int es, ec;
    out_ready = 1'b1;
    for (int i = 1; i <= ARRAY_SIZE; i++) push(i, 1'b0);
    es = model_sum(); ec = mdl_q.size(); mdl_q.delete();
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_eval_valid: got %b required 0", out_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_eval_ready: got %b required 0", in_ready); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL full_valid_n2: got %b required 1", out_valid); end
    total++; if (out_sum !== OUTPUT_BW'(es)) begin bad++; $display("FAIL full_sum: got %0d required %0d", out_sum, es); end
    total++; if (out_count !== 4'(ec)) begin bad++; $display("FAIL full_count: got %0d required %0d", out_count, ec); end
    $display("full batch: sum=%0d count=%0d", out_sum, out_count);
    @(negedge clk);
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL full_after_hold: in_ready=%b out_valid=%b required 1,0", in_ready, out_valid);
    end
  endtask

  task automatic test_extremes;
    int pat[2] = '{-128, 127};
    int es, ec;
    bit to;
    out_ready = 1'b1;
    foreach (pat[p]) begin
      for (int i = 0; i < ARRAY_SIZE; i++) push(pat[p], 1'b0);
      es = model_sum(); ec = mdl_q.size(); mdl_q.delete();
      wait_out(to);
      total++; if (to) begin bad++; $display("FAIL extreme_timeout: out_valid=%b required 1", out_valid); end
      total++; if (out_sum !== OUTPUT_BW'(es)) begin bad++; $display("FAIL extreme_sum: got %0d required %0d", out_sum, es); end
      total++; if (out_count !== 4'(ec)) begin bad++; $display("FAIL extreme_count: got %0d required %0d", out_count, ec); end
      $display("extreme batch of %0d: sum=%0d count=%0d", pat[p], out_sum, out_count);
      @(negedge clk);
    end
  endtask

  task automatic test_short;
    int es, ec, want;
    bit to;
    out_ready = 1'b1;
    push(5, 1'b0);
    push(-3, 1'b0);
    push(7, 1'b1);
    for (int k = 0; k < ARRAY_SIZE; k++) begin
      want = (k < mdl_q.size()) ? mdl_q[k] : 0;
      total++;
      if (operands[k] !== INPUT_BW'(want)) begin bad++; $display("FAIL short_slot%0d: got %0d required %0d", k, operands[k], want); end
    end
    es = model_sum(); ec = mdl_q.size(); mdl_q.delete();
    wait_out(to);
    total++; if (to) begin bad++; $display("FAIL short_timeout: out_valid=%b required 1", out_valid); end
    total++; if (out_sum !== OUTPUT_BW'(es)) begin bad++; $display("FAIL short_sum: got %0d required %0d", out_sum, es); end
    total++; if (out_count !== 4'(ec)) begin bad++; $display("FAIL short_count: got %0d required %0d", out_count, ec); end
    $display("short batch: sum=%0d count=%0d", out_sum, out_count);
    @(negedge clk);
  endtask

  task automatic test_hold;
    int es, x0;
    bit to;
    out_ready = 1'b0;
    for (int i = 1; i <= ARRAY_SIZE; i++) push(i, 1'b0);
    es = model_sum(); mdl_q.delete();
    wait_out(to);
    total++; if (to) begin bad++; $display("FAIL hold_timeout: out_valid=%b required 1", out_valid); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_valid c%0d: got %b required 1", c, out_valid); end
      total++; if (out_sum !== OUTPUT_BW'(es)) begin bad++; $display("FAIL hold_sum c%0d: got %0d required %0d", c, out_sum, es); end
`ifndef OPERAND_COLLECTOR_OVERLAP_EN
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready c%0d: got %b required 0", c, in_ready); end
`endif
    end
    x0 = xfer_cnt;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (xfer_cnt !== x0 + 1) begin bad++; $display("FAIL hold_xfers: got %0d required %0d", xfer_cnt - x0, 1); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_release_valid: got %b required 0", out_valid); end
    $display("held batch: sum=%0d transfers=%0d", es, xfer_cnt - x0);
  endtask

  task automatic test_rst_mid;
    int es, ec, x0;
    bit seen, to;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(int'($urandom_range(0, 255)), 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mdl_q.delete();
    x0 = xfer_cnt;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen || xfer_cnt != x0) begin bad++; $display("FAIL rst_mid_output: seen=%b xfers=%0d required 0,0", seen, xfer_cnt - x0); end
    for (int i = 0; i < ARRAY_SIZE; i++) push(1, 1'b0);
    es = model_sum(); ec = mdl_q.size(); mdl_q.delete();
    wait_out(to);
    total++; if (to) begin bad++; $display("FAIL rst_mid_timeout: out_valid=%b required 1", out_valid); end
    total++; if (out_sum !== OUTPUT_BW'(es) || out_count !== 4'(ec)) begin
      bad++; $display("FAIL rst_mid_batch: got %0d/%0d required %0d/%0d", out_sum, out_count, es, ec);
    end
    $display("after mid-batch reset: sum=%0d count=%0d", out_sum, out_count);
    @(negedge clk);
  endtask

  task automatic test_random;
    int len, es, ec;
    bit last, to;
    for (int b = 0; b < 8; b++) begin
      out_ready = 1'b0;
      len = int'($urandom_range(1, ARRAY_SIZE));
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        last = (i == len - 1) && ((len < ARRAY_SIZE) || ($urandom_range(0, 1) == 1));
        push(int'($urandom_range(0, 255)), last);
      end
      es = model_sum(); ec = mdl_q.size(); mdl_q.delete();
      wait_out(to);
      total++; if (to) begin bad++; $display("FAIL rand_timeout b%0d: out_valid=%b required 1", b, out_valid); end
      total++; if (out_sum !== OUTPUT_BW'(es)) begin bad++; $display("FAIL rand_sum b%0d: got %0d required %0d", b, out_sum, es); end
      total++; if (out_count !== 4'(ec)) begin bad++; $display("FAIL rand_count b%0d: got %0d required %0d", b, out_count, ec); end
      $display("random batch %0d: len=%0d sum=%0d count=%0d", b, len, out_sum, out_count);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back;
    int ea, eb, t;
    xfer_cyc_q.delete();
    xfer_sum_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < ARRAY_SIZE; i++) push(int'($urandom_range(0, 255)), 1'b0);
    ea = model_sum(); mdl_q.delete();
    for (int i = 0; i < ARRAY_SIZE; i++) push(int'($urandom_range(0, 255)), 1'b0);
    eb = model_sum(); mdl_q.delete();
    t = 0;
    while (xfer_cyc_q.size() < 2 && t < 60) begin @(negedge clk); t++; end
    total++;
    if (xfer_cyc_q.size() < 2) begin
      bad++; $display("FAIL b2b_timeout: transfers=%0d required 2", xfer_cyc_q.size());
    end else begin
      total += 2;
      if (xfer_sum_q[0] != ea) begin bad++; $display("FAIL b2b_sum_a: got %0d required %0d", xfer_sum_q[0], ea); end
      if (xfer_sum_q[1] != eb) begin bad++; $display("FAIL b2b_sum_b: got %0d required %0d", xfer_sum_q[1], eb); end
      if (xfer_cyc_q[1] - xfer_cyc_q[0] != PERIOD) begin
        bad++; $display("FAIL b2b_period: got %0d required %0d", xfer_cyc_q[1] - xfer_cyc_q[0], PERIOD);
      end
      $display("back-to-back: sums=%0d,%0d period=%0d", xfer_sum_q[0], xfer_sum_q[1], xfer_cyc_q[1] - xfer_cyc_q[0]);
    end
  endtask

`ifdef OPERAND_COLLECTOR_OVERLAP_EN
  task automatic test_overlap;
    int e1, e2;
    bit to;
    out_ready = 1'b0;
    for (int i = 1; i <= ARRAY_SIZE; i++) push(i, 1'b0);
    e1 = model_sum(); mdl_q.delete();
    wait_out(to);
    total++; if (to) begin bad++; $display("FAIL ovl_timeout: out_valid=%b required 1", out_valid); end
    for (int i = 0; i < ARRAY_SIZE; i++) push(2, 1'b0);
    e2 = model_sum(); mdl_q.delete();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ovl_full_ready: got %b required 0", in_ready); end
    total++; if (out_valid !== 1'b1 || out_sum !== OUTPUT_BW'(e1)) begin
      bad++; $display("FAIL ovl_held: valid=%b sum=%0d required 1,%0d", out_valid, out_sum, e1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovl_gap_valid: got %b required 0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_sum !== OUTPUT_BW'(e2)) begin
      bad++; $display("FAIL ovl_second: valid=%b sum=%0d required 1,%0d", out_valid, out_sum, e2);
    end
    $display("overlap: first=%0d second=%0d", e1, out_sum);
    @(negedge clk);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full();
    test_extremes();
    test_short();
    test_hold();
    test_rst_mid();
    test_random();
    test_back_to_back();
`ifdef OPERAND_COLLECTOR_OVERLAP_EN
    test_overlap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
